// File: rtl/proc_pkg.sv
// Shared encodings for the sequencer and control unit: state codes, bus sources, ALU functions.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package proc_pkg;

  typedef enum logic [5:0] {
    S_IDLE   = 6'd0,
    S_FETCH1 = 6'd1,
    S_FETCH2 = 6'd2,
    S_FETCH3 = 6'd3,
    S_FETCH4 = 6'd4,
    S_FETCH5 = 6'd5,
    S_CLAC   = 6'd6,
    S_LDAC1  = 6'd7,
    S_LDAC2  = 6'd8,
    S_LDAC3  = 6'd9,
    S_LDAC4  = 6'd10,
    S_STAC1  = 6'd11,
    S_STAC2  = 6'd12,
    S_STAC3  = 6'd13,
    S_STAC4  = 6'd14,
    S_MVACR  = 6'd15,
    S_MVRAC  = 6'd16,
    S_ADD    = 6'd17,
    S_MUL    = 6'd18
  } state_e;

  // Highest legal state code; anything above is treated as illegal.
  localparam logic [5:0] LAST_STATE = 6'd18;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_DR   = 3'd2,
    BUS_AC   = 3'd3,
    BUS_R    = 3'd4,
    BUS_MEM  = 3'd5
  } bus_sel_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_MUL  = 2'd2
  } alu_op_e;

  // One decoded control word for the datapath.
  typedef struct packed {
    logic     ar_load;
    logic     pc_inc;
    logic     mem_rd;
    logic     mem_wr;
    logic     dr_load;
    logic     ir_load;
    logic     ac_load;
    logic     ac_clear;
    logic     r_load;
    bus_sel_e bus_sel;
    alu_op_e  alu_op;
  } ctrl_t;

  // True for the last state of every instruction's execute phase.
  function automatic logic is_retire(input logic [5:0] s);
    return (s == S_CLAC)  || (s == S_LDAC4) || (s == S_STAC4) ||
           (s == S_MVACR) || (s == S_MVRAC) || (s == S_ADD)   ||
           (s == S_MUL);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from sequencer state code to the datapath control word.
// Latency: zero cycles (pure combinational; the parent registers the result).
// Backpressure: none; a new state is decoded every cycle.
import proc_pkg::*;

module ctrl_decode (
  input  logic [5:0] state,
  output ctrl_t      ctrl
);

  // Every field idles at zero; each legal state row raises only its own strobes.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH1, S_LDAC1, S_STAC1: begin
        ctrl.bus_sel = BUS_PC;
        ctrl.ar_load = 1'b1;
      end
      S_FETCH2, S_LDAC2, S_STAC2: begin
        ctrl.mem_rd = 1'b1;
        ctrl.pc_inc = 1'b1;
      end
      S_FETCH3, S_LDAC3, S_STAC3: begin
        ctrl.bus_sel = BUS_MEM;
        ctrl.dr_load = 1'b1;
      end
      S_FETCH4: begin
        ctrl.bus_sel = BUS_DR;
        ctrl.ir_load = 1'b1;
      end
      S_CLAC: ctrl.ac_clear = 1'b1;
      S_LDAC4: begin
        ctrl.bus_sel = BUS_DR;
        ctrl.ac_load = 1'b1;
        ctrl.alu_op  = ALU_PASS;
      end
      S_STAC4: begin
        ctrl.bus_sel = BUS_AC;
        ctrl.mem_wr  = 1'b1;
      end
      S_MVACR: begin
        ctrl.bus_sel = BUS_AC;
        ctrl.r_load  = 1'b1;
      end
      S_MVRAC: begin
        ctrl.bus_sel = BUS_R;
        ctrl.ac_load = 1'b1;
        ctrl.alu_op  = ALU_PASS;
      end
      S_ADD: begin
        ctrl.bus_sel = BUS_R;
        ctrl.ac_load = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      S_MUL: begin
        ctrl.bus_sel = BUS_R;
        ctrl.ac_load = 1'b1;
        ctrl.alu_op  = ALU_MUL;
      end
      // idle, fetch5 and illegal codes keep the all-zero default
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Registers decoded datapath strobes and tracks retired count, halt pulse, illegal flag and busy.
// Latency: one cycle from state sample to every output.
// Backpressure: none; the sequencer state is consumed every cycle.
import proc_pkg::*;

module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       state,
  output logic             ar_load,
  output logic             pc_inc,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             dr_load,
  output logic             ir_load,
  output logic             ac_load,
  output logic             ac_clear,
  output logic             r_load,
  output logic [2:0]       bus_sel,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             illegal,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0] prev_state;
  ctrl_t      dec;

  ctrl_decode u_decode (
    .state (state),
    .ctrl  (dec)
  );

  // Register the control word and status; reset wins over every other update.
  always_ff @(posedge clock) begin
    if (reset) begin
      ar_load    <= 1'b0;
      pc_inc     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      dr_load    <= 1'b0;
      ir_load    <= 1'b0;
      ac_load    <= 1'b0;
      ac_clear   <= 1'b0;
      r_load     <= 1'b0;
      bus_sel    <= 3'd0;
      alu_op     <= 2'd0;
      retired    <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      busy       <= 1'b0;
      prev_state <= S_IDLE;
    end else begin
      ar_load    <= dec.ar_load;
      pc_inc     <= dec.pc_inc;
      mem_rd     <= dec.mem_rd;
      mem_wr     <= dec.mem_wr;
      dr_load    <= dec.dr_load;
      ir_load    <= dec.ir_load;
      ac_load    <= dec.ac_load;
      ac_clear   <= dec.ac_clear;
      r_load     <= dec.r_load;
      bus_sel    <= dec.bus_sel;
      alu_op     <= dec.alu_op;
      // counter wraps naturally at its width
      if (is_retire(state))
        retired <= retired + CNT_ONE;
      halted     <= (prev_state == S_FETCH5) && (state == S_IDLE);
      illegal    <= illegal || (state > LAST_STATE);
      busy       <= (state != S_IDLE);
      prev_state <= state;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected outputs queued at drive time, popped after each edge.
// Latency: checks outputs one cycle after each driven state.
// Backpressure: none.
module tb_control_unit;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    state = 6'd0;
  logic          ar_load, pc_inc, mem_rd, mem_wr, dr_load, ir_load, ac_load, ac_clear, r_load;
  logic [2:0]    bus_sel;
  logic [1:0]    alu_op;
  logic [CW-1:0] retired;
  logic          halted, illegal, busy;

  control_unit #(.CNT_W(CW)) dut (
    .clock    (clock),
    .reset    (reset),
    .state    (state),
    .ar_load  (ar_load),
    .pc_inc   (pc_inc),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .dr_load  (dr_load),
    .ir_load  (ir_load),
    .ac_load  (ac_load),
    .ac_clear (ac_clear),
    .r_load   (r_load),
    .bus_sel  (bus_sel),
    .alu_op   (alu_op),
    .retired  (retired),
    .halted   (halted),
    .illegal  (illegal),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // strobes ordered: ar_load pc_inc mem_rd mem_wr dr_load ir_load ac_load ac_clear r_load
  typedef struct {
    logic [8:0]    strobes;
    logic [2:0]    bus;
    logic [1:0]    alu;
    logic [CW-1:0] retired;
    logic          halted;
    logic          illegal;
    logic          busy;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] m_retired = '0;
  logic          m_illegal = 1'b0;
  logic [5:0]    m_prev    = 6'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: written straight from the state table.
  function automatic exp_t model(input logic [5:0] s, input logic r);
    exp_t e;
    e.strobes = 9'b0; e.bus = 3'd0; e.alu = 2'd0;
    if (r) begin
      m_retired = '0; m_illegal = 1'b0; m_prev = 6'd0;
      e.retired = '0; e.halted = 1'b0; e.illegal = 1'b0; e.busy = 1'b0;
      return e;
    end
    case (s)
      6'd1, 6'd7, 6'd11:  begin e.strobes = 9'b100000000; e.bus = 3'd1; end
      6'd2, 6'd8, 6'd12:  e.strobes = 9'b011000000;
      6'd3, 6'd9, 6'd13:  begin e.strobes = 9'b000010000; e.bus = 3'd5; end
      6'd4:               begin e.strobes = 9'b000001000; e.bus = 3'd2; end
      6'd6:               e.strobes = 9'b000000010;
      6'd10:              begin e.strobes = 9'b000000100; e.bus = 3'd2; end
      6'd14:              begin e.strobes = 9'b000100000; e.bus = 3'd3; end
      6'd15:              begin e.strobes = 9'b000000001; e.bus = 3'd3; end
      6'd16:              begin e.strobes = 9'b000000100; e.bus = 3'd4; end
      6'd17:              begin e.strobes = 9'b000000100; e.bus = 3'd4; e.alu = 2'd1; end
      6'd18:              begin e.strobes = 9'b000000100; e.bus = 3'd4; e.alu = 2'd2; end
      default: ;
    endcase
    if (s == 6'd6 || s == 6'd10 || s == 6'd14 || (s >= 6'd15 && s <= 6'd18))
      m_retired = m_retired + 1'b1;
    if (s > 6'd18) m_illegal = 1'b1;
    e.halted  = (m_prev == 6'd5) && (s == 6'd0);
    e.retired = m_retired;
    e.illegal = m_illegal;
    e.busy    = (s != 6'd0);
    m_prev    = s;
    return e;
  endfunction

  // Drive at the falling edge and queue what the next rising edge must produce.
  task automatic drive(input logic [5:0] s, input logic r);
    @(negedge clock);
    state = s;
    reset = r;
    sb.push_back(model(s, r));
  endtask

  // Pop one expectation per rising edge once something is outstanding.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("strobes", {ar_load, pc_inc, mem_rd, mem_wr, dr_load, ir_load, ac_load, ac_clear, r_load}, e.strobes);
        check("bus_sel", bus_sel, e.bus);
        check("alu_op",  alu_op,  e.alu);
        check("retired", retired, e.retired);
        check("halted",  halted,  e.halted);
        check("illegal", illegal, e.illegal);
        check("busy",    busy,    e.busy);
        check("rd_wr_excl", mem_rd & mem_wr, 1'b0);
      end
    end
  end

  initial begin
    // reset held two cycles over a mid-instruction state, then ldac1 decodes
    drive(6'd7, 1'b1);
    drive(6'd7, 1'b1);
    drive(6'd7, 1'b0);
    drive(6'd8, 1'b0);
    drive(6'd9, 1'b0);
    drive(6'd10, 1'b0);
    // fetch then clac then fetch1
    for (int i = 1; i <= 6; i++) drive(6'(i), 1'b0);
    drive(6'd1, 1'b0);
    // fetch to idle: halt pulse
    for (int i = 2; i <= 5; i++) drive(6'(i), 1'b0);
    drive(6'd0, 1'b0);
    drive(6'd0, 1'b0);
    // 16 adds from a clean counter: wraps to 0 on the last
    drive(6'd0, 1'b1);
    for (int i = 0; i < 16; i++) drive(6'd17, 1'b0);
    // store, moves, mul, repeated states
    for (int i = 11; i <= 18; i++) drive(6'(i), 1'b0);
    drive(6'd18, 1'b0);
    drive(6'd2, 1'b0);
    drive(6'd2, 1'b0);
    // illegal code is silent and sticky, then fetch1 still decodes
    drive(6'd25, 1'b0);
    drive(6'd1, 1'b0);
    drive(6'd1, 1'b0);
    drive(6'd63, 1'b0);
    drive(6'd0, 1'b0);
    // reset overrides an illegal code
    drive(6'd25, 1'b1);
    drive(6'd1, 1'b0);
    // reset overrides a pending counter wrap
    for (int i = 0; i < 15; i++) drive(6'd18, 1'b0);
    drive(6'd17, 1'b1);
    drive(6'd6, 1'b0);
    // random mix of legal codes, occasional illegal codes and resets
    for (int i = 0; i < 300; i++) begin
      logic [5:0] s;
      logic       r;
      s = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(19, 63)) : 6'($urandom_range(0, 18));
      r = ($urandom_range(0, 39) == 0);
      drive(s, r);
    end
    drive(6'd0, 1'b0);
    @(posedge clock);
    #3;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
